// File: rtl/game_board_pkg.sv
// Shared definitions for the tic-tac-toe game board controller.
//   SQ_EMPTY/SQ_P1/SQ_P2 : 2-bit square encodings
//   NUM_SQUARES          : board size (3x3, row-major, squares 1..9)
//   state_t              : controller FSM states
//   player_mark()        : square encoding written by a given mover
package ttt_pkg;

  localparam int NUM_SQUARES = 9;

  localparam logic [1:0] SQ_EMPTY = 2'b00;
  localparam logic [1:0] SQ_P1    = 2'b01;
  localparam logic [1:0] SQ_P2    = 2'b10;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WIN   = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  // current_player 0 moves as player 1, 1 moves as player 2
  function automatic logic [1:0] player_mark(input logic player);
    return player ? SQ_P2 : SQ_P1;
  endfunction

endpackage

// File: rtl/game_board_if.sv
// Move/board bus between the game board and its environment.
//   master : drives new_game, move_valid, move_square, player_win
//   slave  : the board; drives square_N_status, current_player, move_ack,
//            move_err, move_count, game_over, winner_id, draw
interface game_board_if;
  logic       new_game;
  logic       move_valid;
  logic [3:0] move_square;
  logic       player_win;
  logic [1:0] square_1_status, square_2_status, square_3_status;
  logic [1:0] square_4_status, square_5_status, square_6_status;
  logic [1:0] square_7_status, square_8_status, square_9_status;
  logic       current_player;
  logic       move_ack;
  logic       move_err;
  logic [3:0] move_count;
  logic       game_over;
  logic [1:0] winner_id;
  logic       draw;

  modport master (
    output new_game, move_valid, move_square, player_win,
    input  square_1_status, square_2_status, square_3_status,
           square_4_status, square_5_status, square_6_status,
           square_7_status, square_8_status, square_9_status,
           current_player, move_ack, move_err, move_count,
           game_over, winner_id, draw
  );

  modport slave (
    input  new_game, move_valid, move_square, player_win,
    output square_1_status, square_2_status, square_3_status,
           square_4_status, square_5_status, square_6_status,
           square_7_status, square_8_status, square_9_status,
           current_player, move_ack, move_err, move_count,
           game_over, winner_id, draw
  );
endinterface

// File: rtl/game_board_turn_timer.sv
// Per-turn idle timer (present only when MOVE_TIMEOUT_EN is defined).
// Down-counter loaded with TIMEOUT_CYCLES-1; fires on terminal count.
//   clk      : system clock
//   clr      : synchronous active-high clear (reload)
//   i_run    : count this cycle (in PLAY with no accepted move)
//   o_expire : one-cycle turn forfeit, counter reloads on the same edge
`ifdef MOVE_TIMEOUT_EN
module turn_timer #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic i_run,
  output logic o_expire
);
  logic [31:0] r_cnt;

  assign o_expire = i_run && (r_cnt == 32'd0);

  // Any cycle not counting reloads, so each entry to PLAY starts a full turn
  always_ff @(posedge clk) begin
    if (clr || !i_run || o_expire) r_cnt <= TIMEOUT_CYCLES - 32'd1;
    else                           r_cnt <= r_cnt - 32'd1;
  end
endmodule
`endif

// File: rtl/game_board.sv
// Tic-tac-toe board controller: validates moves, stores the board, tracks
// the player to move and resolves WIN/DRAW from the external win flag.
//   clk, clr : system clock, synchronous active-high reset
//   bus      : game_board_if.slave (move request in, board/status out)
// Optional feature macro MOVE_TIMEOUT_EN adds the turn_timer forfeit after
// TIMEOUT_CYCLES idle cycles in PLAY.
//
//   state | meaning
//   PLAY  | waiting for a move from current_player
//   CHECK | one cycle: sample player_win against the updated board
//   WIN   | game over, last mover won; holds until clr/new_game
//   DRAW  | game over, board full, no line; holds until clr/new_game
module game_board
  import ttt_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       clr,
  game_board_if.slave bus
);
  state_t     r_state, w_state_nxt;
  logic [1:0] r_board [1:NUM_SQUARES];
  logic       r_player;
  logic [3:0] r_count;
  logic       r_ack, r_err;
  logic       w_target_free, w_accept, w_reject, w_toggle, w_expire;
  logic       w_restart;

  assign w_restart = clr || bus.new_game;

  // Out-of-range indices (0, 10..15) never match, so they read as occupied
  always_comb begin
    w_target_free = 1'b0;
    for (int i = 1; i <= NUM_SQUARES; i++)
      if (bus.move_square == 4'(i)) w_target_free = (r_board[i] == SQ_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (w_restart) r_state <= ST_PLAY;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_toggle    = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (bus.move_valid) begin
          if (w_target_free) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_CHECK;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      // Win is tested before the full-board check so a ninth-move line wins
      ST_CHECK: begin
        if (bus.player_win)                     w_state_nxt = ST_WIN;
        else if (r_count == 4'(NUM_SQUARES))    w_state_nxt = ST_DRAW;
        else begin
          w_state_nxt = ST_PLAY;
          w_toggle    = 1'b1;
        end
      end
      ST_WIN, ST_DRAW: w_state_nxt = r_state;
      default:         w_state_nxt = ST_PLAY;
    endcase
  end

`ifdef MOVE_TIMEOUT_EN
  logic w_timer_run;
  assign w_timer_run = (r_state == ST_PLAY) && !w_accept;

  turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_turn_timer (
    .clk      (clk),
    .clr      (w_restart),
    .i_run    (w_timer_run),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
  // Parameter is kept so instantiations are identical with or without the timer
  if (TIMEOUT_CYCLES == 32'd0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (w_restart) begin
      for (int i = 1; i <= NUM_SQUARES; i++) r_board[i] <= SQ_EMPTY;
      r_player <= 1'b0;
      r_count  <= 4'd0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_ack <= w_accept;
      r_err <= w_reject || w_expire;
      if (w_accept) begin
        for (int i = 1; i <= NUM_SQUARES; i++)
          if (bus.move_square == 4'(i)) r_board[i] <= player_mark(r_player);
        r_count <= r_count + 4'd1;
      end
      if (w_toggle || w_expire) r_player <= ~r_player;
    end
  end

  assign bus.square_1_status = r_board[1];
  assign bus.square_2_status = r_board[2];
  assign bus.square_3_status = r_board[3];
  assign bus.square_4_status = r_board[4];
  assign bus.square_5_status = r_board[5];
  assign bus.square_6_status = r_board[6];
  assign bus.square_7_status = r_board[7];
  assign bus.square_8_status = r_board[8];
  assign bus.square_9_status = r_board[9];
  assign bus.current_player  = r_player;
  assign bus.move_ack        = r_ack;
  assign bus.move_err        = r_err;
  assign bus.move_count      = r_count;
  assign bus.game_over       = (r_state == ST_WIN) || (r_state == ST_DRAW);
  assign bus.draw            = (r_state == ST_DRAW);
  // In WIN the player register still holds the last mover
  assign bus.winner_id       = (r_state == ST_WIN) ? player_mark(r_player) : SQ_EMPTY;
endmodule

// File: tb/tb_game_board.sv
module tb_game_board;
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  game_board_if bus();
  game_board #(.TIMEOUT_CYCLES(32'd16)) dut (.clk(clk), .clr(clr), .bus(bus));

  function automatic logic three(input logic [17:0] b, input int a, input int c, input int d);
    logic [1:0] x, y, z;
    x = b[2*a-2 +: 2];
    y = b[2*c-2 +: 2];
    z = b[2*d-2 +: 2];
    return (x != 2'b00) && (x == y) && (y == z);
  endfunction

  function automatic logic has_line(input logic [17:0] b);
    return three(b,1,2,3) || three(b,4,5,6) || three(b,7,8,9) ||
           three(b,1,4,7) || three(b,2,5,8) || three(b,3,6,9) ||
           three(b,1,5,9) || three(b,3,5,7);
  endfunction

  // External win-detect stage, driven from the board outputs
  logic [17:0] w_board;
  assign w_board = {bus.square_9_status, bus.square_8_status, bus.square_7_status,
                    bus.square_6_status, bus.square_5_status, bus.square_4_status,
                    bus.square_3_status, bus.square_2_status, bus.square_1_status};
  assign bus.player_win = has_line(w_board);

  // Reference model: 0 PLAY, 1 WIN, 2 DRAW
  logic [17:0] m_board;
  logic        m_player;
  int          m_count;
  int          m_state;
  logic [1:0]  exp_q[$];   // 2'b01 ack, 2'b10 err
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [3:0] seq [9];
    int         len;
    logic [3:0] exp_count;
    logic       exp_player;
    logic       exp_over;
    logic       exp_draw;
    logic [1:0] exp_winner;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.move_ack === 1'b1 || bus.move_err === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: got ack=%0b err=%0b, expected no response",
                 bus.move_ack, bus.move_err);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({bus.move_err, bus.move_ack} !== e) begin
          n_fail++;
          $display("FAIL resp: got err/ack=%b, expected %b", {bus.move_err, bus.move_ack}, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_board  = '0;
    m_player = 1'b0;
    m_count  = 0;
    m_state  = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "/board"},  32'(w_board),            32'(m_board));
    check({tag, "/player"}, 32'(bus.current_player), 32'(m_player));
    check({tag, "/count"},  32'(bus.move_count),     32'(m_count));
    check({tag, "/over"},   32'(bus.game_over),      32'(m_state != 0));
    check({tag, "/draw"},   32'(bus.draw),           32'(m_state == 2));
    check({tag, "/winner"}, 32'(bus.winner_id),
          (m_state == 1) ? (m_player ? 32'd2 : 32'd1) : 32'd0);
  endtask

  task automatic new_game_pulse();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    model_reset();
  endtask

  // Drive one request at a negedge, then allow accept + CHECK to complete
  task automatic do_move(input logic [3:0] sq);
    int   idx;
    logic legal;
    idx   = int'(sq);
    legal = 1'b0;
    if (m_state == 0 && idx >= 1 && idx <= 9)
      legal = (m_board[2*idx-2 +: 2] == 2'b00);
    bus.move_valid  = 1'b1;
    bus.move_square = sq;
    if (m_state == 0) exp_q.push_back(legal ? 2'b01 : 2'b10);
    @(negedge clk);
    bus.move_valid  = 1'b0;
    bus.move_square = 4'd0;
    if (legal) begin
      m_board[2*idx-2 +: 2] = m_player ? 2'b10 : 2'b01;
      m_count++;
      if (has_line(m_board))  m_state = 1;
      else if (m_count == 9)  m_state = 2;
      else                    m_player = ~m_player;
    end
    @(negedge clk);
  endtask

  task automatic play_vec(input int k);
    string tag;
    tag = $sformatf("vec%0d", k);
    new_game_pulse();
    for (int j = 0; j < vecs[k].len; j++) do_move(vecs[k].seq[j]);
    check_model(tag);
    check({tag, "/tbl_count"},  32'(bus.move_count),     32'(vecs[k].exp_count));
    check({tag, "/tbl_player"}, 32'(bus.current_player), 32'(vecs[k].exp_player));
    check({tag, "/tbl_over"},   32'(bus.game_over),      32'(vecs[k].exp_over));
    check({tag, "/tbl_draw"},   32'(bus.draw),           32'(vecs[k].exp_draw));
    check({tag, "/tbl_winner"}, 32'(bus.winner_id),      32'(vecs[k].exp_winner));
    check({tag, "/pending"},    32'(exp_q.size()),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{seq: '{1,4,2,5,3,0,0,0,0}, len: 5, exp_count: 4'd5, exp_player: 1'b0,
                exp_over: 1'b1, exp_draw: 1'b0, exp_winner: 2'b01};
    vecs[1] = '{seq: '{5,5,0,0,0,0,0,0,0}, len: 2, exp_count: 4'd1, exp_player: 1'b1,
                exp_over: 1'b0, exp_draw: 1'b0, exp_winner: 2'b00};
    vecs[2] = '{seq: '{0,12,0,0,0,0,0,0,0}, len: 2, exp_count: 4'd0, exp_player: 1'b0,
                exp_over: 1'b0, exp_draw: 1'b0, exp_winner: 2'b00};
    vecs[3] = '{seq: '{1,2,3,5,4,6,8,7,9}, len: 9, exp_count: 4'd9, exp_player: 1'b0,
                exp_over: 1'b1, exp_draw: 1'b1, exp_winner: 2'b00};
    vecs[4] = '{seq: '{1,4,2,5,6,7,8,9,3}, len: 9, exp_count: 4'd9, exp_player: 1'b0,
                exp_over: 1'b1, exp_draw: 1'b0, exp_winner: 2'b01};
    vecs[5] = '{seq: '{1,4,2,5,9,6,0,0,0}, len: 6, exp_count: 4'd6, exp_player: 1'b1,
                exp_over: 1'b1, exp_draw: 1'b0, exp_winner: 2'b10};
    vecs[6] = '{seq: '{15,10,3,3,11,0,0,0,0}, len: 5, exp_count: 4'd1, exp_player: 1'b1,
                exp_over: 1'b0, exp_draw: 1'b0, exp_winner: 2'b00};

    clr             = 1'b1;
    bus.new_game    = 1'b0;
    bus.move_valid  = 1'b0;
    bus.move_square = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_model("reset");
    check("reset/ack", 32'(bus.move_ack), 32'd0);
    check("reset/err", 32'(bus.move_err), 32'd0);

    for (int k = 1; k < 7; k++) play_vec(k);

    // Row-1 win by player 1, then moves in WIN are ignored, then new_game
    play_vec(0);
    check("vec0/squares", 32'(w_board), 32'h00295);
    do_move(4'd7);
    check_model("win_ignore");
    bus.new_game    = 1'b1;
    bus.move_valid  = 1'b1;
    bus.move_square = 4'd7;
    @(negedge clk);
    bus.new_game    = 1'b0;
    bus.move_valid  = 1'b0;
    bus.move_square = 4'd0;
    model_reset();
    check_model("newgame_in_win");
    @(negedge clk);
    check("newgame_in_win/pending", 32'(exp_q.size()), 32'd0);
    check("newgame_in_win/count",   32'(bus.move_count), 32'd0);

    // new_game beats a simultaneous legal move in PLAY
    do_move(4'd2);
    bus.new_game    = 1'b1;
    bus.move_valid  = 1'b1;
    bus.move_square = 4'd1;
    @(negedge clk);
    bus.new_game    = 1'b0;
    bus.move_valid  = 1'b0;
    bus.move_square = 4'd0;
    model_reset();
    @(negedge clk);
    check_model("newgame_in_play");

    // clr during CHECK throws away a pending winning move
    new_game_pulse();
    do_move(4'd1); do_move(4'd4); do_move(4'd2); do_move(4'd5);
    bus.move_valid  = 1'b1;
    bus.move_square = 4'd3;
    exp_q.push_back(2'b01);
    @(negedge clk);
    bus.move_valid  = 1'b0;
    bus.move_square = 4'd0;
    clr             = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    check_model("clr_in_check");
    @(negedge clk);
    check("clr_in_check/pending", 32'(exp_q.size()), 32'd0);

`ifdef MOVE_TIMEOUT_EN
    new_game_pulse();
    exp_q.push_back(2'b10);
    repeat (15) @(negedge clk);
    check("timeout/before_player", 32'(bus.current_player), 32'd0);
    @(negedge clk);
    check("timeout/after_player", 32'(bus.current_player), 32'd1);
    check("timeout/board", 32'(w_board), 32'd0);
    @(negedge clk);
    check("timeout/pending", 32'(exp_q.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_board.md
GAME_BOARD -- requirements
Module: game_board

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 32'd100_000_000, idle cycles allowed per turn when MOVE_TIMEOUT_EN is defined.
- REQ-002: clk  input  1  single system clock; all state updates on rising edge.
- REQ-003: clr  input  1  synchronous, active-high reset.
- REQ-004: new_game  input  1  single-cycle pulse; clears the board and starts a new game.
- REQ-005: move_valid  input  1  move request strobe.
- REQ-006: move_square  input  4  target square, 1..9, row-major (1 = top-left, 9 = bottom-right).
- REQ-007: player_win  input  1  combinational three-in-a-row flag from the win-detect stage, computed from this block's square outputs.
- REQ-008: square_1_status..square_9_status  output  2 each  registered square state: 00 empty, 01 player 1, 10 player 2.
- REQ-009: current_player  output  1  0 = player 1 to move, 1 = player 2 to move.
- REQ-010: move_ack  output  1  one-cycle pulse when a move is accepted.
- REQ-011: move_err  output  1  one-cycle pulse when a move is rejected.
- REQ-012: move_count  output  4  number of occupied squares, 0..9.
- REQ-013: game_over  output  1  high in WIN or DRAW.
- REQ-014: winner_id  output  2  00 none, 01 player 1, 10 player 2; valid only in WIN.
- REQ-015: draw  output  1  high in DRAW.

Function
- REQ-016: The FSM SHALL have exactly the states PLAY, CHECK, WIN and DRAW.
- REQ-017: PLAY, move_valid=1: a move SHALL be accepted only if move_square is in 1..9 and that square is 00.
- REQ-018: On an accepted move:
  - the square is written 01 if current_player=0, else 10;
  - move_count increments;
  - move_ack pulses on the next cycle;
  - the FSM goes to CHECK.
- REQ-019: On a rejected move (index 0, 10..15, or square occupied), the board and player SHALL stay unchanged, move_err SHALL pulse, and the FSM SHALL remain in PLAY.
- REQ-020: move_valid SHALL be ignored in CHECK, WIN and DRAW, with no ack and no err.
- REQ-021: CHECK SHALL last exactly one cycle and sample player_win against the updated board:
  - player_win=1 -> WIN, with winner_id = last mover;
  - else move_count=9 -> DRAW;
  - else toggle current_player -> PLAY.
- REQ-022: A win on the ninth move SHALL resolve to WIN, not DRAW.
- REQ-023: WIN and DRAW SHALL hold until clr or new_game.
- REQ-024: new_game SHALL return the block to its reset state from any state, one cycle later.
- REQ-025: When new_game and move_valid are both high in the same cycle, new_game SHALL win and the move SHALL be discarded.
- REQ-026: Move-to-next-move latency SHALL be 2 cycles minimum: accept, then CHECK.

Reset
- REQ-027: clr SHALL be sampled only on a clk edge and SHALL override all other inputs.
- REQ-028: clr SHALL set the following values:
  - all squares 00;
  - current_player 0;
  - move_count 0;
  - move_ack, move_err, game_over, draw 0;
  - winner_id 00;
  - FSM in PLAY;
  - turn timer cleared.
- REQ-029: clr asserted during CHECK SHALL discard the pending result.

Configuration
- REQ-030: With macro MOVE_TIMEOUT_EN defined, a turn timer SHALL behave as follows:
  - it counts cycles while in PLAY;
  - it restarts on every accepted move and on every entry to PLAY;
  - when TIMEOUT_CYCLES is reached with no accepted move, it forfeits the turn: current_player toggles, the board is unchanged, and move_err pulses.
- REQ-031: With MOVE_TIMEOUT_EN undefined, there SHALL be no timer logic, and a turn SHALL wait indefinitely.

Structure
- REQ-032: Shared package ttt_pkg SHALL hold the following:
  - square encodings SQ_EMPTY=2'b00, SQ_P1=2'b01, SQ_P2=2'b10;
  - the FSM state typedef;
  - constant NUM_SQUARES=9.
- REQ-033: The turn timer SHALL be a sub-module turn_timer, instantiated only under MOVE_TIMEOUT_EN.

Verification
- REQ-034: The bench SHALL cover these directed scenarios:
  - Moves 1,4,2,5,3 -> square_1..3=01, square_4..5=10, WIN, winner_id=01, move_count=5.
  - After a move on square 5, a second move on square 5 -> move_err pulse, board unchanged, current_player unchanged.
  - move_square=0, then move_square=12 -> two move_err pulses, move_count stays 0.
  - Full no-win sequence 1,2,3,5,4,6,8,7,9 -> DRAW, draw=1, winner_id=00, move_count=9.
  - Ninth move completes a line -> WIN, draw=0.
  - new_game while move_valid is high in WIN -> all squares 00, current_player 0, PLAY, no move_ack.
  - With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=16, 16 idle cycles -> current_player toggles, move_err pulses once.
